// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, S-boxes, controller state encodings and GF(2^8) helper
// Used by aes_encipher / aes_enc_round and the decipher core.
package aes_pkg;
  localparam logic [3:0] AES128_ROUNDS = 4'hA;
  localparam logic [3:0] AES256_ROUNDS = 4'hE;
  localparam logic KEYLEN_128 = 1'b0;
  localparam logic KEYLEN_256 = 1'b1;
  typedef enum logic [1:0] {ENC_IDLE, ENC_MAIN, ENC_FINAL} enc_state_e;
  typedef enum logic [1:0] {DEC_IDLE, DEC_INIT, DEC_MAIN} dec_state_e;
  // Byte 0 of each table sits in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[11'd2047 - {x, 3'b000} -: 8];
  endfunction
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX_TBL[11'd2047 - {x, 3'b000} -: 8];
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/aes_enc_round.sv
// aes_enc_round: combinational AES encryption round (SubBytes, ShiftRows, MixColumns, AddRoundKey)
// Ports: state (128b round input), key (128b round key), final_flag (skip MixColumns), result (128b).
module aes_enc_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] key,
  input  logic         final_flag,
  output logic [127:0] result
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a [4];
    logic [31:0] mix;
    // Row r of column c takes the byte from column (c+r)%4: ShiftRows folded into the S-box fetch.
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign a[r] = sbox(state[127-8*(4*((c+r)%4)+r) -: 8]);
    end
    assign mix = {xtime(a[0]) ^ xtime(a[1]) ^ a[1] ^ a[2] ^ a[3],
                  a[0] ^ xtime(a[1]) ^ xtime(a[2]) ^ a[2] ^ a[3],
                  a[0] ^ a[1] ^ xtime(a[2]) ^ xtime(a[3]) ^ a[3],
                  xtime(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xtime(a[3])};
    assign result[127-32*c -: 32] = (final_flag ? {a[0], a[1], a[2], a[3]} : mix) ^ key[127-32*c -: 32];
  end
endmodule

// File: rtl/aes_encipher.sv
// aes_encipher: iterative AES-128/256 block encryptor, one round per clock
// Ports: clk, rst (sync, active high), next (start), keylen (0=128,1=256), round (key index requested),
// round_key (same-cycle key), block (plaintext), new_block (ciphertext), ready (one-cycle done pulse).
// Optional: define AES_ENC_ABORT_EN to add input abort, which cancels a running operation.
module aes_encipher
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
`ifdef AES_ENC_ABORT_EN
  input  logic         abort,
`endif
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);
  enc_state_e state_q, state_d;
  logic [3:0] round_q, round_d, nr;
  logic [127:0] block_q, block_d, rnd_out;
  logic keylen_q, keylen_d, ready_q, ready_d, abort_w;
`ifdef AES_ENC_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif
  assign nr = (keylen_q == KEYLEN_256) ? AES256_ROUNDS : AES128_ROUNDS;
  aes_enc_round u_round (
    .state(block_q),
    .key(round_key),
    .final_flag(state_q == ENC_FINAL),
    .result(rnd_out)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ENC_IDLE;
      round_q  <= '0;
      block_q  <= '0;
      keylen_q <= KEYLEN_128;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      block_q  <= block_d;
      keylen_q <= keylen_d;
      ready_q  <= ready_d;
    end
  end
  always_comb begin
    state_d = ENC_IDLE;
    if (state_q == ENC_IDLE) state_d = next ? ENC_MAIN : ENC_IDLE;
    else if (abort_w) state_d = ENC_IDLE;
    else if (state_q == ENC_MAIN) state_d = (round_q == nr - 4'd1) ? ENC_FINAL : ENC_MAIN;
  end
  always_comb begin
    round_d  = round_q;
    block_d  = block_q;
    keylen_d = keylen_q;
    ready_d  = 1'b0;
    if (state_q == ENC_IDLE) begin
      if (next) begin
        block_d  = block ^ round_key;
        keylen_d = keylen;
        round_d  = 4'd1;
      end
    end else if (abort_w) begin
      round_d = '0;
      block_d = '0;
    end else begin
      block_d = rnd_out;
      round_d = (state_q == ENC_FINAL) ? 4'd0 : round_q + 4'd1;
      ready_d = state_q == ENC_FINAL;
    end
  end
  assign round     = round_q;
  assign new_block = block_q;
  assign ready     = ready_q;
endmodule

// File: tb/tb_aes_encipher.sv
// tb_aes_encipher: directed FIPS-197 vector bench for aes_encipher with a key-schedule memory model
module tb_aes_encipher;
  import aes_pkg::*;
  logic clk = 1'b0;
  logic rst, next, keylen;
`ifdef AES_ENC_ABORT_EN
  logic abort;
`endif
  logic [3:0] round;
  logic [127:0] round_key, block, new_block;
  logic ready;
  logic [127:0] rk [16];
  logic [3:0] rseq [16];
  int n_cmp = 0;
  int n_bad = 0;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY_C = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  aes_encipher dut (
    .clk(clk),
    .rst(rst),
`ifdef AES_ENC_ABORT_EN
    .abort(abort),
`endif
    .next(next),
    .keylen(keylen),
    .round(round),
    .round_key(round_key),
    .block(block),
    .new_block(new_block),
    .ready(ready)
  );

  always #5 clk = ~clk;
  assign round_key = rk[round];

  // FIPS-197 key expansion into the round-key memory model.
  task automatic load_key(input logic [255:0] key, input logic kl);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    int nk, nw;
    nk = kl ? 8 : 4;
    nw = kl ? 60 : 44;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = {sbox(t[23:16]) ^ rc, sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk == 8 && i % nk == 4) begin
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    rk[15] = '0;
  endtask

  // Starts one block and waits (bounded) for ready; lat counts edges from acceptance to ready.
  task automatic run_enc(input logic [127:0] pt, input logic kl, input logic disturb,
                         output logic [127:0] ct, output int lat);
    @(negedge clk);
    rseq[0] = round;
    next = 1'b1;
    block = pt;
    keylen = kl;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat < 16) rseq[lat] = round;
      next = disturb && (lat == 3 || lat == 7);
      keylen = (disturb && (lat == 3 || lat == 7)) ? ~kl : kl;
    end while (!ready && lat < 40);
    ct = new_block;
    next = 1'b0;
    keylen = kl;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    next = 1'b0;
    keylen = 1'b0;
    block = '0;
`ifdef AES_ENC_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    n_cmp++;
    if (round !== 4'd0) begin n_bad++; $display("FAIL reset_round got %h want 0", round); end
    n_cmp++;
    if (new_block !== 128'h0) begin n_bad++; $display("FAIL reset_new_block got %h want 0", new_block); end
    n_cmp++;
    if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b want 0", ready); end
    rst = 1'b0;
  endtask

  task automatic test_app_b;
    logic [127:0] ct;
    int lat;
    load_key({KEY_B, 128'h0}, 1'b0);
    run_enc(PT_B, 1'b0, 1'b0, ct, lat);
    n_cmp++;
    if (ct !== CT_B) begin n_bad++; $display("FAIL appb_ct got %h want %h", ct, CT_B); end
    n_cmp++;
    if (lat !== 11) begin n_bad++; $display("FAIL appb_latency got %0d want 11", lat); end
  endtask

  task automatic test_c1;
    logic [127:0] ct;
    int lat;
    load_key({KEY_C[255:128], 128'h0}, 1'b0);
    run_enc(PT_C, 1'b0, 1'b0, ct, lat);
    n_cmp++;
    if (ct !== CT_C1) begin n_bad++; $display("FAIL c1_ct got %h want %h", ct, CT_C1); end
    n_cmp++;
    if (lat !== 11) begin n_bad++; $display("FAIL c1_latency got %0d want 11", lat); end
    for (int k = 0; k < 12; k++) begin
      n_cmp++;
      if (rseq[k] !== ((k <= 10) ? 4'(k) : 4'd0)) begin
        n_bad++;
        $display("FAIL c1_round_seq[%0d] got %0d want %0d", k, rseq[k], (k <= 10) ? k : 0);
      end
    end
  endtask

  task automatic test_c3;
    logic [127:0] ct;
    int lat;
    load_key(KEY_C, 1'b1);
    run_enc(PT_C, 1'b1, 1'b0, ct, lat);
    n_cmp++;
    if (ct !== CT_C3) begin n_bad++; $display("FAIL c3_ct got %h want %h", ct, CT_C3); end
    n_cmp++;
    if (lat !== 15) begin n_bad++; $display("FAIL c3_latency got %0d want 15", lat); end
  endtask

  task automatic test_busy_ignore;
    logic [127:0] ct;
    int lat;
    load_key({KEY_C[255:128], 128'h0}, 1'b0);
    run_enc(PT_C, 1'b0, 1'b1, ct, lat);
    n_cmp++;
    if (ct !== CT_C1) begin n_bad++; $display("FAIL busy_ct got %h want %h", ct, CT_C1); end
    n_cmp++;
    if (lat !== 11) begin n_bad++; $display("FAIL busy_latency got %0d want 11", lat); end
  endtask

  task automatic test_reset_mid_run;
    logic [127:0] ct;
    int lat;
    logic seen;
    load_key({KEY_C[255:128], 128'h0}, 1'b0);
    @(negedge clk);
    next = 1'b1;
    block = PT_C;
    keylen = 1'b0;
    @(negedge clk);
    next = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (round !== 4'd0) begin n_bad++; $display("FAIL midrst_round got %0d want 0", round); end
    n_cmp++;
    if (new_block !== 128'h0) begin n_bad++; $display("FAIL midrst_new_block got %h want 0", new_block); end
    n_cmp++;
    if (ready !== 1'b0) begin n_bad++; $display("FAIL midrst_ready got %b want 0", ready); end
    seen = 1'b0;
    repeat (16) begin
      @(negedge clk);
      if (ready || round !== 4'd0) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL midrst_stays_idle got %b want 0", seen); end
    run_enc(PT_C, 1'b0, 1'b0, ct, lat);
    n_cmp++;
    if (ct !== CT_C1) begin n_bad++; $display("FAIL midrst_rerun_ct got %h want %h", ct, CT_C1); end
    n_cmp++;
    if (lat !== 11) begin n_bad++; $display("FAIL midrst_rerun_latency got %0d want 11", lat); end
  endtask

  task automatic test_back_to_back;
    logic [127:0] ct1, ct2;
    int first, second;
    load_key({KEY_B, 128'h0}, 1'b0);
    @(negedge clk);
    next = 1'b1;
    block = PT_B;
    keylen = 1'b0;
    first = 0;
    second = 0;
    ct1 = '0;
    ct2 = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (ready && first == 0) begin first = k; ct1 = new_block; end
      else if (ready && second == 0) begin second = k; ct2 = new_block; end
    end
    next = 1'b0;
    repeat (16) @(negedge clk);
    n_cmp++;
    if (first !== 11) begin n_bad++; $display("FAIL b2b_first_ready got %0d want 11", first); end
    n_cmp++;
    if (second !== 22) begin n_bad++; $display("FAIL b2b_second_ready got %0d want 22", second); end
    n_cmp++;
    if (ct1 !== CT_B) begin n_bad++; $display("FAIL b2b_ct1 got %h want %h", ct1, CT_B); end
    n_cmp++;
    if (ct2 !== CT_B) begin n_bad++; $display("FAIL b2b_ct2 got %h want %h", ct2, CT_B); end
  endtask

`ifdef AES_ENC_ABORT_EN
  task automatic test_abort;
    logic [127:0] ct;
    int lat;
    logic hit;
    load_key({KEY_B, 128'h0}, 1'b0);
    @(negedge clk);
    next = 1'b1;
    block = PT_B;
    keylen = 1'b0;
    @(negedge clk);
    next = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      if (round == 4'd4) hit = 1'b1;
      else @(negedge clk);
    end
    n_cmp++;
    if (hit !== 1'b1) begin n_bad++; $display("FAIL abort_reach_round4 got %b want 1", hit); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++;
    if (round !== 4'd0) begin n_bad++; $display("FAIL abort_round got %0d want 0", round); end
    n_cmp++;
    if (new_block !== 128'h0) begin n_bad++; $display("FAIL abort_new_block got %h want 0", new_block); end
    n_cmp++;
    if (ready !== 1'b0) begin n_bad++; $display("FAIL abort_ready got %b want 0", ready); end
    run_enc(PT_B, 1'b0, 1'b0, ct, lat);
    n_cmp++;
    if (ct !== CT_B) begin n_bad++; $display("FAIL abort_rerun_ct got %h want %h", ct, CT_B); end
    n_cmp++;
    if (lat !== 11) begin n_bad++; $display("FAIL abort_rerun_latency got %0d want 11", lat); end
  endtask
`endif

  initial begin
    test_reset();
    test_app_b();
    test_c1();
    test_c3();
    test_busy_ignore();
    test_reset_mid_run();
    test_back_to_back();
`ifdef AES_ENC_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/aes_encipher.md
Name: aes_encipher

Overview:
- Iterative AES block encryptor: one round per clock on a 128-bit state. Supports AES-128 (10 rounds) and AES-256 (14 rounds).
- Encrypt-direction companion of the existing decipher core. Same key-request interface: the block drives `round`, and the external key-schedule memory returns `round_key` combinationally in the same cycle.
- Sits between the block-mode controller (which drives `next` and `block`) and the shared round-key store.

Parameters:
- NONE_FIXED_WIDTH, n/a — no parameters. The block width (128) and round counts are fixed constants from `aes_pkg`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `next` in 1: start request; sampled only in IDLE.
- `keylen` in 1: 0 = AES-128, 1 = AES-256; latched when `next` is accepted.
- `round` out 4: index of the round key requested this cycle.
- `round_key` in 128: round key for index `round`; must be valid in the same cycle.
- `block` in 128: plaintext; sampled in the cycle `next` is accepted.
- `new_block` out 128: ciphertext; held stable until the next accepted start.
- `ready` out 1: one-cycle pulse, asserted in the same cycle `new_block` first holds the ciphertext.

Behaviour:
- Byte order follows FIPS-197:
  - byte 0 = `block[127:120]`; the state is column-major (bytes 0-3 = column 0).
  - ShiftRows rotates row r left by r.
  - MixColumns uses the matrix {02,03,01,01} over GF(2^8), reduction polynomial 0x11B.
- Reset (when `rst` = 1 at a rising edge): state=IDLE, `round`=0, `new_block`=0, `ready`=0, latched keylen=0. Reset mid-operation aborts the operation with no `ready` pulse.
- Nr = 10 when latched keylen=0, 14 when latched keylen=1.
- States: IDLE, MAIN, FINAL.
- IDLE:
  - `round`=0.
  - If `next`=1: `block_reg` <= `block` ^ `round_key` (key 0), latch keylen, `round` <= 1, go to MAIN.
  - Otherwise hold all registers.
- MAIN:
  - `block_reg` <= MixColumns(ShiftRows(SubBytes(`block_reg`))) ^ `round_key`; `round` <= `round`+1.
  - If `round` == Nr-1, go to FINAL; otherwise stay in MAIN.
- FINAL (`round`=Nr):
  - `block_reg` <= ShiftRows(SubBytes(`block_reg`)) ^ `round_key`.
  - `ready` <= 1, `round` <= 0, go to IDLE.
- `ready` is registered and is high for exactly the one cycle after FINAL; it is 0 otherwise.
- Latency:
  - `next` accepted at edge E, `ready`=1 in the cycle after edge E+Nr.
  - That is 11 cycles for AES-128 and 15 cycles for AES-256.
  - Throughput is one block per Nr+1 cycles; back-to-back operation is allowed.
- `next` and `keylen` are ignored outside IDLE. Changing `keylen` mid-operation has no effect.
- `next` held high continuously: the block restarts in the cycle `ready` is high, i.e. IDLE accepts the request immediately.
- `round` never exceeds Nr and wraps to 0 only via FINAL or reset.

Optional Feature:
- Macro: `AES_ENC_ABORT_EN`.
- Defined:
  - Adds input port `abort` (1 bit). `abort`=1 in MAIN or FINAL forces the next state to IDLE, with `round`=0 and `new_block`=0. No `ready` pulse is produced.
  - `abort` in IDLE is ignored. When `abort` and `next` are both high in IDLE, `next` wins.
- Undefined: no `abort` port; behaviour is exactly as described above.

Decomposition:
- `aes_pkg` (shared with the decipher core):
  - forward sbox table and inverse sbox table;
  - `AES128_ROUNDS`=4'hA and `AES256_ROUNDS`=4'hE;
  - keylen encodings;
  - enc/dec state encodings;
  - `xtime` GF helper function.
- Sub-module `aes_enc_round`: purely combinational. Inputs are `state`, `key` and `final_flag`. Output is SubBytes, then ShiftRows, then MixColumns (skipped when `final_flag`=1), then AddRoundKey.
- The FSM, round counter and registers stay in `aes_encipher`.

Test Plan:
- FIPS-197 App. B (bench key-schedule model):
  - stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, `block`=3243f6a8885a308d313198a2e0370734, `keylen`=0, pulse `next`;
  - required response: `ready` 11 cycles later, `new_block`=3925841d02dc09fbdc118597196a0b32.
- FIPS-197 C.1:
  - stimulus: key 000102…0f, pt 00112233445566778899aabbccddeeff;
  - required response: ct 69c4e0d86a7b0430d8cdb78070b4c55a; `round` sequence 0,1,…,10,0.
- FIPS-197 C.3 (AES-256):
  - stimulus: key 000102…1f, same pt;
  - required response: `ready` after 15 cycles, ct 8ea2b7ca516745bfeafc49904b496089.
- Busy-ignore:
  - stimulus: re-pulse `next` and toggle `keylen` at cycles 3 and 7 of a C.1 run;
  - required response: result and latency unchanged.
- Reset mid-run:
  - stimulus: `rst`=1 at cycle 5;
  - required response: next cycle `round`=0, `new_block`=0, `ready`=0; a subsequent C.1 run passes.
- With `AES_ENC_ABORT_EN`:
  - stimulus: `abort`=1 at round 4;
  - required response: IDLE, `new_block`=0, no `ready` pulse; a following App. B run passes back-to-back.
